// File: rtl/fd_pipe_skid.sv
// Fetch->decode pipeline register with valid/ready handshake, flush and bubble insertion.
// SKID=1 adds a second entry so in_ready is a flop with no combinational input.
module fd_pipe_skid #(
  parameter int unsigned          IR_W     = 32,
  parameter int unsigned          PC_W     = 32,
  parameter logic [IR_W-1:0]      NOP_INSN = '0,
  parameter bit                   SKID     = 1'b1
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IR_W-1:0] in_ir,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IR_W-1:0] out_ir,
  output logic [PC_W-1:0] out_pc,
  output logic [1:0]      occupancy
);

  // state    | meaning
  // ST_EMPTY | nothing held, out_* carry the bubble
  // ST_ONE   | one beat, in the output register
  // ST_FULL  | two beats: oldest in output register, newest in skid (SKID=1 only)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [IR_W-1:0] out_ir_q, out_ir_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic [IR_W-1:0] skid_ir_q, skid_ir_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            in_ready_q, in_ready_d;

  logic accept;
  logic issue;

  // Without a skid entry the stage can take a beat only if the held one leaves.
  assign in_ready  = SKID ? in_ready_q : (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_ir    = out_ir_q;
  assign out_pc    = out_pc_q;
  assign occupancy = state_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_ir_d    = out_ir_q;
    out_pc_d    = out_pc_q;
    skid_ir_d   = skid_ir_q;
    skid_pc_d   = skid_pc_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      out_valid_d = 1'b0;
      out_ir_d    = NOP_INSN;
      out_pc_d    = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            out_valid_d = 1'b1;
            out_ir_d    = in_ir;
            out_pc_d    = in_pc;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            out_ir_d = in_ir;
            out_pc_d = in_pc;
          end else if (accept && SKID) begin
            state_d   = ST_FULL;
            skid_ir_d = in_ir;
            skid_pc_d = in_pc;
          end else if (issue) begin
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
            out_ir_d    = NOP_INSN;
            out_pc_d    = '0;
          end
        end
        ST_FULL: begin
          if (issue) begin
            state_d  = ST_ONE;
            out_ir_d = skid_ir_q;
            out_pc_d = skid_pc_q;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          out_valid_d = 1'b0;
          out_ir_d    = NOP_INSN;
          out_pc_d    = '0;
        end
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_ir_q    <= NOP_INSN;
      out_pc_q    <= '0;
      skid_ir_q   <= '0;
      skid_pc_q   <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ir_q    <= out_ir_d;
      out_pc_q    <= out_pc_d;
      skid_ir_q   <= skid_ir_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_fd_pipe_skid.sv
// Directed bench: skid variant (dut) and single-entry variant (dut0, non-zero NOP).
`timescale 1ns/1ps
module tb_fd_pipe_skid;

  localparam logic [31:0] NOP0 = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clrn;

  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_ir, in_pc, out_ir, out_pc;
  logic [1:0]  occupancy;

  logic        in_valid0, in_ready0, flush0, out_valid0, out_ready0;
  logic [31:0] in_ir0, in_pc0, out_ir0, out_pc0;
  logic [1:0]  occupancy0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fd_pipe_skid #(.IR_W(32), .PC_W(32), .NOP_INSN(32'h0), .SKID(1'b1)) dut (
    .clk(clk), .clrn(clrn),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  fd_pipe_skid #(.IR_W(32), .PC_W(32), .NOP_INSN(NOP0), .SKID(1'b0)) dut0 (
    .clk(clk), .clrn(clrn),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ir(in_ir0), .in_pc(in_pc0),
    .flush(flush0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ir(out_ir0), .out_pc(out_pc0),
    .occupancy(occupancy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ir    = ir_of(pc);
  endtask

  initial begin
    clrn = 1'b0;
    drive(1'b0, 32'h0);
    flush = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; in_ir0 = '0; in_pc0 = '0; flush0 = 1'b0; out_ready0 = 1'b0;

    // 1: reset values
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ir", out_ir, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst0_out_ir", out_ir0, NOP0);
    chk("rst0_in_ready", in_ready0, 1);
    clrn = 1'b1;
    step(); step();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_occ", occupancy, 0);
    chk("idle_in_ready", in_ready, 1);

    // 2: streaming
    out_ready = 1'b1;
    drive(1'b1, 32'h00); step();
    chk("s0_valid", out_valid, 1);
    chk("s0_pc", out_pc, 32'h00);
    chk("s0_ir", out_ir, ir_of(32'h00));
    chk("s0_occ", occupancy, 1);
    drive(1'b1, 32'h04); step();
    chk("s1_pc", out_pc, 32'h04);
    chk("s1_occ", occupancy, 1);
    drive(1'b1, 32'h08); step();
    chk("s2_pc", out_pc, 32'h08);
    chk("s2_ir", out_ir, ir_of(32'h08));
    chk("s2_occ", occupancy, 1);
    drive(1'b0, 32'h0); step();
    chk("s3_valid", out_valid, 0);
    chk("s3_bubble_ir", out_ir, 0);
    chk("s3_bubble_pc", out_pc, 0);
    chk("s3_occ", occupancy, 0);

    // 3: stall into the skid entry, then drain
    out_ready = 1'b0;
    drive(1'b1, 32'h10); step();
    chk("st0_pc", out_pc, 32'h10);
    chk("st0_occ", occupancy, 1);
    chk("st0_in_ready", in_ready, 1);
    drive(1'b1, 32'h14); step();
    chk("st1_occ", occupancy, 2);
    chk("st1_in_ready", in_ready, 0);
    chk("st1_pc", out_pc, 32'h10);
    drive(1'b1, 32'h18); step();
    chk("st2_hold_pc", out_pc, 32'h10);
    chk("st2_hold_ir", out_ir, ir_of(32'h10));
    chk("st2_occ", occupancy, 2);
    drive(1'b0, 32'h0);
    out_ready = 1'b1; step();
    chk("dr0_pc", out_pc, 32'h14);
    chk("dr0_occ", occupancy, 1);
    chk("dr0_in_ready", in_ready, 1);
    step();
    chk("dr1_valid", out_valid, 0);
    chk("dr1_occ", occupancy, 0);

    // 4: flush at FULL with a beat offered
    out_ready = 1'b0;
    drive(1'b1, 32'h18); step();
    drive(1'b1, 32'h1C); step();
    chk("fl_pre_occ", occupancy, 2);
    drive(1'b1, 32'h20);
    flush = 1'b1; step();
    chk("fl_valid", out_valid, 0);
    chk("fl_ir", out_ir, 0);
    chk("fl_pc", out_pc, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1; step();
    chk("fl_after_valid", out_valid, 0);
    // flush in ONE while a beat is accepted: the accepted beat is discarded
    drive(1'b1, 32'h24); step();
    chk("fl1_pre_pc", out_pc, 32'h24);
    drive(1'b1, 32'h28);
    flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("fl1_valid", out_valid, 0);
    chk("fl1_occ", occupancy, 0);
    step();
    chk("fl1_after_valid", out_valid, 0);

    // 5: single-entry variant, combinational ready
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_pc0 = 32'h50; in_ir0 = ir_of(32'h50); step();
    chk("p0_valid", out_valid0, 1);
    chk("p0_pc", out_pc0, 32'h50);
    chk("p0_occ", occupancy0, 1);
    in_pc0 = 32'h54; in_ir0 = ir_of(32'h54); #1;
    chk("p0_in_ready_stall", in_ready0, 0);
    step();
    chk("p0_hold_pc", out_pc0, 32'h50);
    out_ready0 = 1'b1; #1;
    chk("p0_in_ready_pass", in_ready0, 1);
    step();
    chk("p1_pc", out_pc0, 32'h54);
    chk("p1_ir", out_ir0, ir_of(32'h54));
    chk("p1_valid", out_valid0, 1);
    in_valid0 = 1'b0; step();
    chk("p2_valid", out_valid0, 0);
    chk("p2_nop", out_ir0, NOP0);
    chk("p2_pc", out_pc0, 0);
    chk("p2_occ", occupancy0, 0);

    // 6: async reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, 32'h30); step();
    drive(1'b1, 32'h34); step();
    chk("rs_pre_occ", occupancy, 2);
    drive(1'b0, 32'h0);
    clrn = 1'b0; #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_occ", occupancy, 0);
    chk("rs_in_ready", in_ready, 1);
    #2 clrn = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h40); step();
    chk("rs_first_valid", out_valid, 1);
    chk("rs_first_pc", out_pc, 32'h40);
    drive(1'b0, 32'h0); step();
    chk("rs_drained", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
